sha2_msg_schedule: RTL and testbench
====================================

// Module: sha2_msg_schedule
// PURPOSE
//  Parametrised SHA-2 message-schedule generator for SHA-224/256 (32-bit words, 64 rounds) and SHA-384/512 (64-bit words, 80 rounds).
//  Accepts one 16-word padded block via valid/ready and streams W[0]..W[NUM_ROUNDS-1] to the compression core, one word per handshake.
//  Supports back-to-back blocks, so multi-block messages stream without idle cycles.
// PARAMETERS
//  WORD_W      32  word width; legal values 32 or 64 only; selects sigma constants
//  NUM_ROUNDS  64  words per block; 64 when WORD_W=32, 80 when WORD_W=64
//  RND_W       7   width of round index output; must be >= clog2(NUM_ROUNDS)
// PORTS
//  clk        in   1            single clock, rising edge
//  Reset      in   1            synchronous reset, active-high
//  blk_valid  in   1            blk_data holds a padded block
//  blk_ready  out  1            block accepted when blk_valid && blk_ready
//  blk_data   in   16*WORD_W    W0 in [WORD_W-1:0] .. W15 in top word
//  w_valid    out  1            w_data/w_round/w_last valid
//  w_ready    in   1            consumer takes word when w_valid && w_ready
//  w_data     out  WORD_W       current schedule word W[t]
//  w_round    out  RND_W        t, 0..NUM_ROUNDS-1
//  w_last     out  1            high with W[NUM_ROUNDS-1]
//  busy       out  1            block in progress (state RUN)
// BEHAVIOUR
//  State: 16-word window (win[0] = oldest), round counter cnt, FSM {IDLE, RUN}.
//  Reset (sampled at clk): state=IDLE, cnt=0, window=0. While Reset is high: w_valid=0, w_last=0, w_round=0, w_data=0, busy=0, blk_ready=0.
//  Reset mid-block discards the block; no further words are emitted.
//  IDLE: blk_ready=1, w_valid=0. On blk_valid && blk_ready: win<=blk_data, cnt<=0, state<=RUN.
//  RUN: w_valid=1, w_data=win[0], w_round=cnt, busy=1, w_last=(cnt==NUM_ROUNDS-1).
//  First word is valid the cycle after block acceptance (latency 1).
//  Handshake in RUN, not last: shift win[i]<=win[i+1] for i=0..14, win[15]<=w_new, cnt<=cnt+1.
//  w_new = s1(win[14]) + win[9] + s0(win[1]) + win[0], sum mod 2^WORD_W (carry discarded).
//  WORD_W=32: s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10.
//  WORD_W=64: s0 = ROTR1^ROTR8^SHR7, s1 = ROTR19^ROTR61^SHR6.
//  w_ready low in RUN: every output holds, no shift (stall for any number of cycles).
//  Last-word handshake: blk_ready = w_last && w_ready (combinational) in RUN.
//   If blk_valid is also high: load new block, cnt<=0, stay in RUN (zero-bubble back-to-back).
//   Otherwise: state<=IDLE, w_valid drops next cycle.
//  blk_ready is 0 in RUN except in the last-word-handshake case; blk_valid is ignored at all other times.
//  cnt never exceeds NUM_ROUNDS-1 and never wraps.
//  Elaboration error if WORD_W is not 32/64 or NUM_ROUNDS > 2**RND_W.
// TESTING
//  T1 W=32 "abc" (W0=0x61626380, W15=0x18, rest 0) -> 64 words; W16=0x61626380, W17=0x000F0000, w_last only on round 63.
//  T2 W=64/R=80 "abc" (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words.
//  T3 random w_ready (50% duty) -> word sequence matches golden model; outputs stable while stalled.
//  T4 two blocks, blk_valid held high -> W[0] of block 2 the cycle after W[63] of block 1, no bubble.
//  T5 Reset pulse at round 20 -> w_valid=0 next cycle, blk_ready=1 after release, fresh block restarts at round 0.
//  T6 blk_valid pulsed during RUN rounds 0..62 -> ignored; current block unaffected.

Source files
------------

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message-schedule generator: takes one 16-word padded block and streams W[0..NUM_ROUNDS-1].
// 32-bit words give SHA-224/256 sigmas; 64-bit words give SHA-384/512 sigmas.
module sha2_msg_schedule #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64,
    parameter int RND_W      = 7
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [16*WORD_W-1:0]   blk_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [WORD_W-1:0]      w_data,
    output logic [RND_W-1:0]       w_round,
    output logic                   w_last,
    output logic                   busy
);

    generate
        if (!(WORD_W == 32 || WORD_W == 64) || (NUM_ROUNDS > 2**RND_W)) begin : g_param_check
            $error("sha2_msg_schedule: WORD_W must be 32 or 64 and NUM_ROUNDS must fit in RND_W bits");
        end
    endgenerate

    localparam int S0_A = (WORD_W == 32) ? 7  : 1;
    localparam int S0_B = (WORD_W == 32) ? 18 : 8;
    localparam int S0_C = (WORD_W == 32) ? 3  : 7;
    localparam int S1_A = (WORD_W == 32) ? 17 : 19;
    localparam int S1_B = (WORD_W == 32) ? 19 : 61;
    localparam int S1_C = (WORD_W == 32) ? 10 : 6;

    localparam logic [RND_W-1:0] LAST_CNT = RND_W'(NUM_ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [WORD_W-1:0]  win_r [16];
    logic [RND_W-1:0]   cnt_r;
    logic [WORD_W-1:0]  w_new_s;
    logic               load_s;
    logic               shift_s;
    logic               finish_s;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    endfunction

    // Next schedule word from the current window, modular sum.
    always_comb begin
        w_new_s = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];
    end

    // Output decode; everything is forced low while Reset is held.
    always_comb begin
        w_valid   = 1'b0;
        busy      = 1'b0;
        w_data    = '0;
        w_round   = '0;
        w_last    = 1'b0;
        blk_ready = 1'b0;
        if (Reset) begin
            blk_ready = 1'b0;
        end else begin
            w_valid = (state_r == RUN);
            busy    = (state_r == RUN);
            w_data  = win_r[0];
            w_round = cnt_r;
            w_last  = (state_r == RUN) && (cnt_r == LAST_CNT);
            if (state_r == IDLE) begin
                blk_ready = 1'b1;
            end else begin
                blk_ready = w_last && w_ready;
            end
        end
    end

    // Handshake qualifiers driving the window and FSM.
    always_comb begin
        load_s   = blk_valid && blk_ready;
        shift_s  = w_valid && w_ready && !w_last;
        finish_s = w_valid && w_ready && w_last;
    end

    // FSM, window shift register and round counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= '0;
            end
        end else begin
            if (load_s) begin
                for (int i = 0; i < 16; i++) begin
                    win_r[i] <= blk_data[i*WORD_W +: WORD_W];
                end
                cnt_r <= '0;
            end else if (shift_s) begin
                for (int i = 0; i < 15; i++) begin
                    win_r[i] <= win_r[i+1];
                end
                win_r[15] <= w_new_s;
                cnt_r     <= cnt_r + RND_W'(1);
            end

            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (finish_s && !load_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Scoreboard bench for sha2_msg_schedule: 32-bit and 64-bit instances checked against a reference schedule.
module tb_sha2_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset;

    logic          blk_valid32, blk_ready32, w_valid32, w_ready32, w_last32, busy32;
    logic [511:0]  blk_data32;
    logic [31:0]   w_data32;
    logic [6:0]    w_round32;

    logic          blk_valid64, blk_ready64, w_valid64, w_ready64, w_last64, busy64;
    logic [1023:0] blk_data64;
    logic [63:0]   w_data64;
    logic [6:0]    w_round64;

    sha2_msg_schedule #(.WORD_W(32), .NUM_ROUNDS(64), .RND_W(7)) dut32 (
        .clk(clk), .Reset(Reset),
        .blk_valid(blk_valid32), .blk_ready(blk_ready32), .blk_data(blk_data32),
        .w_valid(w_valid32), .w_ready(w_ready32), .w_data(w_data32),
        .w_round(w_round32), .w_last(w_last32), .busy(busy32)
    );

    sha2_msg_schedule #(.WORD_W(64), .NUM_ROUNDS(80), .RND_W(7)) dut64 (
        .clk(clk), .Reset(Reset),
        .blk_valid(blk_valid64), .blk_ready(blk_ready64), .blk_data(blk_data64),
        .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64),
        .w_round(w_round64), .w_last(w_last64), .busy(busy64)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  rnd;
        logic        last;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 1'b0;

    function automatic logic [31:0] ss0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
    function automatic logic [63:0] ss0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction
    function automatic logic [63:0] ss1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp32(input logic [511:0] d, input bit abc);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = d[32*t +: 32];
        for (int t = 16; t < 64; t++) w[t] = ss1_32(w[t-2]) + w[t-7] + ss0_32(w[t-15]) + w[t-16];
        if (abc) begin
            w[16] = 32'h61626380;
            w[17] = 32'h000F0000;
        end
        for (int t = 0; t < 64; t++) q32.push_back('{data: {32'h0, w[t]}, rnd: 7'(t), last: (t == 63)});
    endtask

    task automatic push_exp64(input logic [1023:0] d, input bit abc);
        logic [63:0] w [80];
        for (int t = 0; t < 16; t++) w[t] = d[64*t +: 64];
        for (int t = 16; t < 80; t++) w[t] = ss1_64(w[t-2]) + w[t-7] + ss0_64(w[t-15]) + w[t-16];
        if (abc) begin
            w[16] = 64'h6162638000000000;
            w[17] = 64'h00030000000000C0;
        end
        for (int t = 0; t < 80; t++) q64.push_back('{data: w[t], rnd: 7'(t), last: (t == 79)});
    endtask

    task automatic send32(input logic [511:0] d, input bit abc);
        bit ok = 1'b0;
        push_exp32(d, abc);
        blk_data32  = d;
        blk_valid32 = 1'b1;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = blk_ready32;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send32_timeout: blk_ready got 0, expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle32();
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = !w_valid32 && (q32.size() == 0);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle32_timeout: pending %0d, expected 0", q32.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_blk(output logic [511:0] d);
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    endtask

    // w_ready driver: always ready, or coin-flip when rand_mode is set.
    initial begin
        w_ready32 = 1'b1;
        forever begin
            @(posedge clk); #1;
            w_ready32 = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor for the 32-bit instance, including stall-hold check.
    initial begin
        exp_t        e;
        logic [31:0] pd;
        logic [6:0]  pr;
        logic        pl;
        bit          pstall;
        pstall = 1'b0;
        pd = '0; pr = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (pstall && !Reset)
                chk("stall_hold32", {24'h0, w_data32, w_round32, w_last32}, {24'h0, pd, pr, pl});
            pstall = 1'b0;
            if (!Reset && w_valid32 === 1'b1) begin
                if (!w_ready32) begin
                    pstall = 1'b1;
                    pd = w_data32; pr = w_round32; pl = w_last32;
                end else if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word32: round %0d, expected no word", w_round32);
                end else begin
                    e = q32.pop_front();
                    chk("word32",  {32'h0, w_data32}, e.data);
                    chk("round32", 64'(w_round32), 64'(e.rnd));
                    chk("last32",  64'(w_last32), 64'(e.last));
                    chk("busy32",  64'(busy32), 64'd1);
                end
            end
        end
    end

    // Scoreboard monitor for the 64-bit instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!Reset && w_valid64 === 1'b1 && w_ready64) begin
                if (q64.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word64: round %0d, expected no word", w_round64);
                end else begin
                    e = q64.pop_front();
                    chk("word64",  w_data64, e.data);
                    chk("round64", 64'(w_round64), 64'(e.rnd));
                    chk("last64",  64'(w_last64), 64'(e.last));
                end
            end
        end
    end

    initial begin
        logic [511:0]  abc32, b1, b2;
        logic [1023:0] abc64;
        bit            found;

        abc32 = '0; abc32[31:0] = 32'h61626380; abc32[511:480] = 32'h00000018;
        abc64 = '0; abc64[63:0] = 64'h6162638000000000; abc64[1023:960] = 64'h18;

        Reset = 1'b1;
        blk_valid32 = 1'b0; blk_data32 = '0;
        blk_valid64 = 1'b0; blk_data64 = '0; w_ready64 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w_valid",   64'(w_valid32), 64'd0);
        chk("rst_blk_ready", 64'(blk_ready32), 64'd0);
        chk("rst_busy",      64'(busy32), 64'd0);
        chk("rst_w_last",    64'(w_last32), 64'd0);
        chk("rst_w_round",   64'(w_round32), 64'd0);
        chk("rst_w_data",    64'(w_data32), 64'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        chk("idle_blk_ready", 64'(blk_ready32), 64'd1);
        chk("idle_w_valid",   64'(w_valid32), 64'd0);
        @(posedge clk); #1;

        // T1: "abc" block, always ready
        send32(abc32, 1'b1);
        blk_valid32 = 1'b0;
        wait_idle32();
        chk("post_busy",      64'(busy32), 64'd0);
        chk("post_blk_ready", 64'(blk_ready32), 64'd1);

        // T3: random backpressure
        rand_mode = 1'b1;
        rand_blk(b1);
        send32(b1, 1'b0);
        blk_valid32 = 1'b0;
        wait_idle32();
        rand_mode = 1'b0;

        // T4: back-to-back blocks with blk_valid held high
        rand_blk(b1);
        rand_blk(b2);
        send32(b1, 1'b0);
        send32(b2, 1'b0);
        blk_valid32 = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(w_valid32), 64'd1);
        chk("b2b_round", 64'(w_round32), 64'd0);
        wait_idle32();

        // T5: Reset pulse at round 20, then a fresh block
        rand_blk(b1);
        send32(b1, 1'b0);
        blk_valid32 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = w_valid32 && (w_round32 == 7'd20);
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL round20_timeout: round %0d, expected 20", w_round32);
        end
        @(posedge clk); #1;
        Reset = 1'b1;
        q32.delete();
        @(negedge clk);
        chk("midrst_w_valid",   64'(w_valid32), 64'd0);
        chk("midrst_blk_ready", 64'(blk_ready32), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        chk("rel_blk_ready", 64'(blk_ready32), 64'd1);
        chk("rel_w_valid",   64'(w_valid32), 64'd0);
        @(posedge clk); #1;
        send32(abc32, 1'b1);
        blk_valid32 = 1'b0;
        wait_idle32();

        // T6: stray blk_valid pulses during RUN must be ignored
        rand_blk(b1);
        send32(b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            blk_data32  = ~b1 ^ 512'(k);
            blk_valid32 = k[0];
            @(negedge clk);
            chk("run_blk_ready", 64'(blk_ready32), 64'd0);
            @(posedge clk); #1;
        end
        blk_valid32 = 1'b0;
        wait_idle32();

        // T2: 64-bit "abc" block, 80 words
        push_exp64(abc64, 1'b1);
        blk_data64  = abc64;
        blk_valid64 = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = blk_ready64;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL send64_timeout: blk_ready got 0, expected 1");
        end
        @(posedge clk); #1;
        blk_valid64 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            found = !w_valid64 && (q64.size() == 0);
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL idle64_timeout: pending %0d, expected 0", q64.size());
        end

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
